// File: rtl/ysyx_23060278_isram_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060278_isram_pkg
//   Shared definitions for the instruction-memory responder. It holds the FSM
//   state encoding, the NOP returned on a bad fetch, and the default byte
//   address of word 0.
//   No ports.
// ---------------------------------------------------------------------------
package ysyx_23060278_isram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } isram_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060278_isram_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060278_isram_if
//   Fetch bus between the core (master) and the instruction memory (slave).
//   It has a request channel and a response channel, each using a valid/ready
//   handshake.
//   Signals:
//     req_valid / req_ready / req_addr            request channel
//     rsp_valid / rsp_ready / rsp_inst / rsp_err  response channel
// ---------------------------------------------------------------------------
interface ysyx_23060278_isram_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_inst;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );

endinterface

// File: rtl/ysyx_23060278_sram_1r1w.sv
// ---------------------------------------------------------------------------
// ysyx_23060278_sram_1r1w
//   Synchronous-read array with one read port and one write port. It has no
//   reset. When a read and a write hit the same index on the same edge, the
//   read returns the contents from before the write.
//   Ports:
//     clk        clock
//     rd_en_i    read enable; rd_data_o updates only when this is high
//     rd_idx_i   read word index
//     rd_data_o  registered read data
//     wr_en_i    write enable
//     wr_idx_i   write word index
//     wr_data_i  write data
// ---------------------------------------------------------------------------
module ysyx_23060278_sram_1r1w #(
  parameter int IDX_W  = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [DATA_W-1:0] rd_data_q;

  // Both ports use non-blocking updates, so a read on the same edge as a
  // write to the same index returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ysyx_23060278_isram.sv
// ---------------------------------------------------------------------------
// ysyx_23060278_isram
//   Instruction-memory responder. It accepts one fetch at a time, waits
//   LATENCY cycles, and then returns the instruction word. It holds the
//   response until the consumer takes it. A misaligned address, or an address
//   outside the 2^IDX_W-word window starting at BASE_ADDR, returns a NOP with
//   rsp_err set.
//   Ports:
//     clk, rst   clock; asynchronous active-high reset
//     bus        fetch bus (slave side)
//     ld_wen     preload write enable
//     ld_idx     preload word index
//     ld_data    preload data
// ---------------------------------------------------------------------------
module ysyx_23060278_isram
  import ysyx_23060278_isram_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                IDX_W     = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                LATENCY   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_23060278_isram_if.slave         bus,
  input  logic                         ld_wen,
  input  logic [IDX_W-1:0]             ld_idx,
  input  logic [31:0]                  ld_data
);

  // The accept edge loads LATENCY-1. The edge that sees zero performs the
  // read, so rsp_valid rises LATENCY edges after the accept.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  isram_state_e      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic [ADDR_W-1:0] off_word;
  logic              addr_err;

  // Word offset from BASE_ADDR, using wrap-around arithmetic. An address
  // below the base wraps to a huge offset and is therefore caught as out of
  // range.
  assign off_word = (addr_q - BASE_ADDR) >> 2;
  assign addr_err = (addr_q[1:0] != 2'b00) || (|off_word[ADDR_W-1:IDX_W]);

  ysyx_23060278_sram_1r1w #(
    .IDX_W  (IDX_W),
    .DATA_W (32)
  ) u_sram (
    .clk       (clk),
    .rd_en_i   (rd_en),
    .rd_idx_i  (off_word[IDX_W-1:0]),
    .rd_data_o (rd_data),
    .wr_en_i   (ld_wen),
    .wr_idx_i  (ld_idx),
    .wr_data_i (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // The array is read only on the WAIT->RESP edge. Its output register then
  // stays frozen for the whole RESP state, even if preload writes arrive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = addr_err;
          rd_en   = !addr_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // req_ready is gated with rst so that it reads 0 while reset is held.
  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
  assign bus.rsp_inst  = (state_q != ST_RESP) ? 32'h0 :
                         (err_q ? INST_NOP : rd_data);

endmodule

// File: tb/tb_ysyx_23060278_isram.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060278_isram
//   Directed bench for the instruction-memory responder at LATENCY=2. It
//   covers the basic fetch, backpressure, the error cases, back-to-back
//   fetches, reset in the middle of a fetch, and a preload write that
//   collides with a read.
// ---------------------------------------------------------------------------
module tb_ysyx_23060278_isram;

  logic        clk;
  logic        rst;
  logic        ld_wen;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;
  int          checks;
  int          failures;

  ysyx_23060278_isram_if #(.ADDR_W(32)) bus ();

  ysyx_23060278_isram #(
    .ADDR_W    (32),
    .IDX_W     (10),
    .BASE_ADDR (32'h8000_0000),
    .LATENCY   (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ld_wen  (ld_wen),
    .ld_idx  (ld_idx),
    .ld_data (ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and land 1 time unit after the rising edge. Checks and
  // new drives both happen at that point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic r);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    ld_wen  = 1'b1;
    ld_idx  = idx;
    ld_data = data;
    step();
    ld_wen  = 1'b0;
  endtask

  // A full fetch with rsp_ready held high. rsp_valid must appear two edges
  // after the accept, and the handshake must return the responder to IDLE.
  task automatic doFetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] expInst, input logic expErr);
    applyStimulus(1'b1, addr, 1'b1);
    step();
    applyStimulus(1'b0, addr, 1'b1);
    checkOutput({tag, "_busy_ready"}, {31'h0, bus.req_ready}, 32'd0);
    step();
    checkOutput({tag, "_wait_valid"}, {31'h0, bus.rsp_valid}, 32'd0);
    step();
    checkOutput({tag, "_valid"}, {31'h0, bus.rsp_valid}, 32'd1);
    checkOutput({tag, "_inst"}, bus.rsp_inst, expInst);
    checkOutput({tag, "_err"}, {31'h0, bus.rsp_err}, {31'h0, expErr});
    step();
    checkOutput({tag, "_done_valid"}, {31'h0, bus.rsp_valid}, 32'd0);
    checkOutput({tag, "_done_ready"}, {31'h0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ld_wen   = 1'b0;
    ld_idx   = '0;
    ld_data  = '0;
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Reset state
    #3;
    checkOutput("rst_req_ready", {31'h0, bus.req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_rsp_inst", bus.rsp_inst, 32'd0);
    checkOutput("rst_rsp_err", {31'h0, bus.rsp_err}, 32'd0);
    #9;
    rst = 1'b0;
    step();
    checkOutput("post_rst_ready", {31'h0, bus.req_ready}, 32'd1);

    $display("[TB] preload");
    preload(10'd0, 32'h0050_0093);
    preload(10'd1, 32'h0010_0113);
    preload(10'd1023, 32'hDEAD_BEEF);

    $display("[TB] basic fetch");
    doFetch("t1", 32'h8000_0000, 32'h0050_0093, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h8000_0004, 1'b0);
    step();
    step();
    step();
    checkOutput("bp_first_valid", {31'h0, bus.rsp_valid}, 32'd1);
    checkOutput("bp_first_inst", bus.rsp_inst, 32'h0010_0113);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("bp_hold_valid%0d", i), {31'h0, bus.rsp_valid}, 32'd1);
      checkOutput($sformatf("bp_hold_inst%0d", i), bus.rsp_inst, 32'h0010_0113);
      checkOutput($sformatf("bp_hold_ready%0d", i), {31'h0, bus.req_ready}, 32'd0);
    end
    applyStimulus(1'b0, 32'h8000_0004, 1'b1);
    step();
    checkOutput("bp_release_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'h0, bus.req_ready}, 32'd1);

    $display("[TB] address errors");
    doFetch("misalign", 32'h8000_0002, 32'h0000_0013, 1'b1);
    doFetch("past_end", 32'h8000_1000, 32'h0000_0013, 1'b1);
    doFetch("below_base", 32'h7FFF_FFFC, 32'h0000_0013, 1'b1);
    doFetch("last_word", 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0);

    // The address changes right after the accept edge. The first response
    // must still carry A's data.
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 32'h8000_0000, 1'b1);
    step();
    applyStimulus(1'b1, 32'h8000_0004, 1'b1);
    checkOutput("b2b_a_busy", {31'h0, bus.req_ready}, 32'd0);
    step();
    step();
    checkOutput("b2b_a_valid", {31'h0, bus.rsp_valid}, 32'd1);
    checkOutput("b2b_a_inst", bus.rsp_inst, 32'h0050_0093);
    step();
    checkOutput("b2b_hs_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkOutput("b2b_hs_ready", {31'h0, bus.req_ready}, 32'd1);
    step();
    checkOutput("b2b_b_accept", {31'h0, bus.req_ready}, 32'd0);
    applyStimulus(1'b0, 32'h8000_0004, 1'b1);
    step();
    step();
    checkOutput("b2b_b_valid", {31'h0, bus.rsp_valid}, 32'd1);
    checkOutput("b2b_b_inst", bus.rsp_inst, 32'h0010_0113);
    step();
    checkOutput("b2b_b_done", {31'h0, bus.rsp_valid}, 32'd0);

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 32'h8000_0004, 1'b1);
    step();
    applyStimulus(1'b0, 32'h8000_0004, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {31'h0, bus.rsp_valid}, 32'd0);
    checkOutput("mid_rst_ready", {31'h0, bus.req_ready}, 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("abandon_valid%0d", i), {31'h0, bus.rsp_valid}, 32'd0);
    end
    doFetch("after_rst", 32'h8000_0000, 32'h0050_0093, 1'b0);

    // The preload write lands on the same edge that reads index 3.
    $display("[TB] read-before-write");
    preload(10'd3, 32'h1111_1111);
    applyStimulus(1'b1, 32'h8000_000C, 1'b1);
    step();
    applyStimulus(1'b0, 32'h8000_000C, 1'b1);
    step();
    ld_wen  = 1'b1;
    ld_idx  = 10'd3;
    ld_data = 32'h2222_2222;
    step();
    ld_wen  = 1'b0;
    checkOutput("rbw_valid", {31'h0, bus.rsp_valid}, 32'd1);
    checkOutput("rbw_old_inst", bus.rsp_inst, 32'h1111_1111);
    step();
    checkOutput("rbw_done", {31'h0, bus.rsp_valid}, 32'd0);
    doFetch("rbw_new", 32'h8000_000C, 32'h2222_2222, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
